writeback_scheduler: RTL and testbench

Sequences the single register-file write port between the pipeline writeback stage and a long-latency unit (load/multi-cycle ALU) and scoreboards that unit's in-flight destinations. Sits directly in front of `register_file`, driving its `write_control` input. It produces a decode stall for RAW/WAW hazards on long-latency results. It applies bounded-wait arbitration so the long-latency unit is never starved.

---
 rtl/writeback_scheduler_pkg.sv | 26 ++
 rtl/writeback_scheduler_scoreboard.sv | 62 ++++++
 rtl/writeback_scheduler.sv | 166 ++++++++++++++++
 tb/tb_writeback_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_scheduler_pkg.sv
// rtl/writeback_scheduler_pkg.sv - shared core types for the writeback scheduler
// Contents:
//   XLEN                 datapath width
//   rv_reg_t             architectural register index
//   reg_write_control_t  register_file write request {enable, which_register, value}
//   wb_arb_state_t       writeback arbiter states (IDLE/CONTEND/FORCE)
package writeback_scheduler_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_CONTEND = 2'd1,
    WB_FORCE   = 2'd2
  } wb_arb_state_t;

endpackage

// File: rtl/writeback_scheduler_scoreboard.sv
// rtl/writeback_scheduler_scoreboard.sv - busy scoreboard for long-latency destinations
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_set_en, i_set_rd        mark a destination busy at the next edge
//   i_clr_en, i_clr_rd        release a destination at the next edge
//   i_rs1, i_rs2              source lookups  -> o_rs1_busy, o_rs2_busy
//   i_waw_rd                  WAW lookup      -> o_waw_busy
//   o_pending                 any busy bit set
//   o_busy                    raw busy vector
module reg_scoreboard
  import writeback_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_set_en,
  input  rv_reg_t             i_set_rd,
  input  logic                i_clr_en,
  input  rv_reg_t             i_clr_rd,
  input  rv_reg_t             i_rs1,
  input  rv_reg_t             i_rs2,
  input  rv_reg_t             i_waw_rd,
  output logic                o_rs1_busy,
  output logic                o_rs2_busy,
  output logic                o_waw_busy,
  output logic                o_pending,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // x0 reads as never busy, and indices beyond NUM_REGS are treated as free.
  function automatic logic lookup(input logic [NUM_REGS-1:0] vec, input rv_reg_t rd);
    lookup = (rd != '0) && (int'(rd) < NUM_REGS) && vec[rd];
  endfunction

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en && (int'(i_set_rd) < NUM_REGS)) w_set_mask[i_set_rd] = 1'b1;
    if (i_clr_en && (int'(i_clr_rd) < NUM_REGS)) w_clr_mask[i_clr_rd] = 1'b1;
  end

  // Bit 0 is masked so x0 can never become busy.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
    end
  end

  assign o_rs1_busy = lookup(r_busy, i_rs1);
  assign o_rs2_busy = lookup(r_busy, i_rs2);
  assign o_waw_busy = lookup(r_busy, i_waw_rd);
  assign o_pending  = |r_busy;
  assign o_busy     = r_busy;

endmodule

// File: rtl/writeback_scheduler.sv
// rtl/writeback_scheduler.sv - register-file write port arbiter and long-latency hazard scoreboard
// Ports:
//   i_clock, i_reset                          clock, asynchronous active-high reset
//   i_pipe_wb / o_pipe_hold                   pipeline writeback request and freeze
//   i_long_valid, i_long_rd, i_long_value     long-latency result
//   o_long_ready                              long-latency result accepted this cycle
//   i_issue_valid, i_issue_rd                 long-latency dispatch
//   i_rs1, i_rs2 / o_stall                    decode sources and hazard stall
//   o_write_control                           registered request to register_file
//   o_pending                                 at least one destination in flight
module writeback_scheduler
  import writeback_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  reg_write_control_t i_pipe_wb,
  output logic               o_pipe_hold,
  input  logic               i_long_valid,
  input  rv_reg_t            i_long_rd,
  input  logic [XLEN-1:0]    i_long_value,
  output logic               o_long_ready,
  input  logic               i_issue_valid,
  input  rv_reg_t            i_issue_rd,
  input  rv_reg_t            i_rs1,
  input  rv_reg_t            i_rs2,
  output logic               o_stall,
  output reg_write_control_t o_write_control,
  output logic               o_pending
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  wb_arb_state_t       r_state;
  wb_arb_state_t       w_state_nxt;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [CNT_W-1:0]    w_wait_cnt_nxt;
  reg_write_control_t  r_wc;
  logic                r_wc_long;

  logic                w_pipe_req;
  logic                w_ready;
  logic                w_hold;
  logic                w_grant_long;
  logic                w_grant_pipe;
  logic                w_stall;
  logic                w_set_en;
  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic                w_waw_busy;
  logic [NUM_REGS-1:0] w_busy_vec;

  // A pipe write to x0 is architecturally a no-op, so it never contends.
  assign w_pipe_req = i_pipe_wb.enable && (i_pipe_wb.which_register != '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ready        = 1'b0;
    w_hold         = 1'b0;
    w_grant_pipe   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (i_long_valid && w_pipe_req) begin
          w_grant_pipe   = 1'b1;
          w_wait_cnt_nxt = CNT_W'(1);
          w_state_nxt    = (CNT_W'(1) == CNT_W'(MAX_WAIT)) ? WB_FORCE : WB_CONTEND;
        end else if (i_long_valid) begin
          w_ready = 1'b1;
        end else begin
          w_grant_pipe = w_pipe_req;
        end
      end
      WB_CONTEND: begin
        if (!i_long_valid) begin
          // Requester withdrew; nothing left to protect from starvation.
          w_grant_pipe   = w_pipe_req;
          w_state_nxt    = WB_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (w_pipe_req) begin
          // Looking at the incremented count means the loss that reaches
          // MAX_WAIT sends us to FORCE, so the long result wins on the next
          // cycle instead of losing once more.
          w_grant_pipe   = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          if (w_wait_cnt_nxt == CNT_W'(MAX_WAIT)) w_state_nxt = WB_FORCE;
        end else begin
          w_ready        = 1'b1;
          w_state_nxt    = WB_IDLE;
          w_wait_cnt_nxt = '0;
        end
      end
      WB_FORCE: begin
        w_ready        = 1'b1;
        w_hold         = 1'b1;
        w_state_nxt    = WB_IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = WB_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  assign w_grant_long = w_ready && i_long_valid;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= WB_IDLE;
      r_wait_cnt <= '0;
      r_wc       <= '0;
      r_wc_long  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_grant_long) begin
        // A long result to x0 is consumed but never written.
        r_wc      <= '{enable: (i_long_rd != '0), which_register: i_long_rd, value: i_long_value};
        r_wc_long <= (i_long_rd != '0);
      end else if (w_grant_pipe) begin
        r_wc      <= i_pipe_wb;
        r_wc_long <= 1'b0;
      end else begin
        r_wc      <= '0;
        r_wc_long <= 1'b0;
      end
    end
  end

  // Busy clears as register_file commits the long write, one edge after the
  // handshake, so stall still sees the pre-clear value in that cycle.
  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_set_en   (w_set_en),
    .i_set_rd   (i_issue_rd),
    .i_clr_en   (r_wc_long),
    .i_clr_rd   (r_wc.which_register),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_waw_rd   (i_issue_rd),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_waw_busy (w_waw_busy),
    .o_pending  (o_pending),
    .o_busy     (w_busy_vec)
  );

  assign w_stall  = !i_reset && (w_rs1_busy || w_rs2_busy || (i_issue_valid && w_waw_busy));
  assign w_set_en = i_issue_valid && !w_stall && (i_issue_rd != '0);

  assign o_stall         = w_stall;
  assign o_long_ready    = !i_reset && w_ready;
  assign o_pipe_hold     = !i_reset && w_hold;
  assign o_write_control = r_wc;

  a_long_rd_busy: assert property (@(posedge i_clock) disable iff (i_reset)
    (i_long_valid && (i_long_rd != '0)) |-> w_busy_vec[i_long_rd])
    else $error("long result presented for non-busy register x%0d", i_long_rd);

endmodule

// File: tb/tb_writeback_scheduler.sv
// tb/tb_writeback_scheduler.sv - scoreboard bench for writeback_scheduler
module tb_writeback_scheduler;
  import writeback_scheduler_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int MAX_WAIT = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  reg_write_control_t pipe_wb;
  logic               pipe_hold;
  logic               long_valid;
  rv_reg_t            long_rd;
  logic [XLEN-1:0]    long_value;
  logic               long_ready;
  logic               issue_valid;
  rv_reg_t            issue_rd;
  rv_reg_t            rs1;
  rv_reg_t            rs2;
  logic               stall;
  reg_write_control_t write_control;
  logic               pending;

  always #5 clock = ~clock;

  writeback_scheduler #(
    .NUM_REGS (NUM_REGS),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_pipe_wb       (pipe_wb),
    .o_pipe_hold     (pipe_hold),
    .i_long_valid    (long_valid),
    .i_long_rd       (long_rd),
    .i_long_value    (long_value),
    .o_long_ready    (long_ready),
    .i_issue_valid   (issue_valid),
    .i_issue_rd      (issue_rd),
    .i_rs1           (rs1),
    .i_rs2           (rs2),
    .o_stall         (stall),
    .o_write_control (write_control),
    .o_pending       (pending)
  );

  typedef struct {
    rv_reg_t         rd;
    logic [XLEN-1:0] value;
    int              due;
  } exp_t;

  exp_t    exp_q[$];
  rv_reg_t cand[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      cyc   = 0;

  // Reference model state: busy destinations, destinations whose result has
  // not yet been presented, consecutive losses of the waiting long result,
  // and the pending busy release one edge after a long handshake.
  bit      m_busy[NUM_REGS];
  bit      m_out[NUM_REGS];
  int      lose_cnt  = 0;
  bit      clr_valid = 0;
  rv_reg_t clr_rd    = '0;
  bit      last_force = 0;
  bit      obs_ready  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_busy[r] = 0;
      m_out[r]  = 0;
    end
    lose_cnt   = 0;
    clr_valid  = 0;
    last_force = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    pipe_wb     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
  endtask

  task automatic present_long(input rv_reg_t rd, input logic [XLEN-1:0] val);
    long_valid = 1'b1;
    long_rd    = rd;
    long_value = val;
    m_out[rd]  = 0;
  endtask

  // One clock cycle: inputs are already applied; evaluate the model at the
  // falling edge, compare the combinational outputs, queue expected writes.
  task automatic step();
    bit preq;
    bit lwin = 0;
    bit pwin = 0;
    bit forced = 0;
    bit exp_stall;
    bit exp_pend = 0;
    @(negedge clock);
    preq = pipe_wb.enable && (pipe_wb.which_register != '0);
    if (long_valid) begin
      forced = (lose_cnt == MAX_WAIT);
      if (forced || !preq) begin
        lwin     = 1;
        lose_cnt = 0;
      end else begin
        pwin     = 1;
        lose_cnt = lose_cnt + 1;
      end
    end else begin
      pwin = preq;
    end
    exp_stall = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) ||
                (issue_valid && issue_rd != 0 && m_busy[issue_rd]);
    for (int r = 0; r < NUM_REGS; r++) exp_pend |= m_busy[r];
    obs_ready = long_ready;
    check("long_ready", 64'(long_ready), 64'(lwin || forced));
    check("pipe_hold",  64'(pipe_hold),  64'(forced));
    check("stall",      64'(stall),      64'(exp_stall));
    check("pending",    64'(pending),    64'(exp_pend));
    if (lwin && long_rd != 0) exp_q.push_back('{long_rd, long_value, cyc + 1});
    if (pwin) exp_q.push_back('{pipe_wb.which_register, pipe_wb.value, cyc + 1});
    if (clr_valid) m_busy[clr_rd] = 0;
    if (issue_valid && !exp_stall && issue_rd != 0) begin
      m_busy[issue_rd] = 1;
      m_out[issue_rd]  = 1;
    end
    clr_valid  = lwin && (long_rd != 0);
    clr_rd     = long_rd;
    last_force = forced;
    @(posedge clock);
    #1;
    cyc++;
    if (lwin) long_valid = 1'b0;
  endtask

  // Monitor: every enabled write_control must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        check("wc_written", 64'(0), 64'(1));
      end
      if (!reset && write_control.enable) begin
        if (exp_q.size() == 0) begin
          check("wc_spurious", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wc_rd",    64'(write_control.which_register), 64'(e.rd));
          check("wc_value", 64'(write_control.value),          64'(e.value));
          check("wc_cycle", 64'(cyc),                          64'(e.due));
        end
      end
    end
  end

  initial begin
    int waited;
    model_reset();
    pipe_wb     = '{enable: 1'b1, which_register: 5'd4, value: 32'h1111_2222};
    long_valid  = 1'b1;
    long_rd     = '0;
    long_value  = '0;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    rs1         = '0;
    rs2         = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wc_enable",  64'(write_control.enable), 64'(0));
    check("rst_wc_reg",     64'(write_control.which_register), 64'(0));
    check("rst_wc_value",   64'(write_control.value), 64'(0));
    check("rst_pending",    64'(pending), 64'(0));
    check("rst_long_ready", 64'(long_ready), 64'(0));
    check("rst_pipe_hold",  64'(pipe_hold), 64'(0));
    check("rst_stall",      64'(stall), 64'(0));
    idle_inputs();
    long_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // RAW: rd=7 in flight, decode waits on it, result arrives uncontended.
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    idle_inputs(); rs1 = 5'd7;
    repeat (3) step();
    present_long(5'd7, 32'hDEAD_BEEF);
    step();
    check("raw_accept", 64'(obs_ready), 64'(1));
    repeat (3) step();

    // Starvation: continuous pipe writes to x3 against a waiting result.
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd4; step();
    idle_inputs();
    present_long(5'd4, 32'h0BAD_F00D);
    waited = 0;
    for (int i = 0; i < 8 && waited == 0; i++) begin
      if (!last_force) pipe_wb = '{enable: 1'b1, which_register: 5'd3, value: $urandom()};
      step();
      if (obs_ready) waited = i + 1;
    end
    check("starve_wait", 64'(waited), 64'(MAX_WAIT + 1));
    step();
    idle_inputs(); repeat (2) step();

    // WAW: second issue to x9 must wait for the first result to retire.
    issue_valid = 1'b1; issue_rd = 5'd9; step();
    repeat (3) step();
    present_long(5'd9, 32'h9999_0001);
    repeat (4) step();
    issue_valid = 1'b0;
    present_long(5'd9, 32'h9999_0002);
    repeat (3) step();

    // x0: pipe write to x0 never contends; long result to x0 is dropped.
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd2; step();
    idle_inputs();
    pipe_wb = '{enable: 1'b1, which_register: 5'd0, value: 32'h0000_1234};
    present_long(5'd2, 32'hCAFE_0002);
    step();
    check("x0_pipe_no_contend", 64'(obs_ready), 64'(1));
    pipe_wb = '0;
    present_long(5'd0, 32'h5555_AAAA);
    step();
    check("x0_long_accept", 64'(obs_ready), 64'(1));
    repeat (3) step();

    // Reset mid-operation with rd=5 busy and a write_control on the wire.
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd5;
    pipe_wb = '{enable: 1'b1, which_register: 5'd6, value: 32'h6666_0006};
    step();
    idle_inputs(); rs1 = 5'd5;
    check("pre_rst_pending", 64'(pending), 64'(1));
    check("pre_rst_wc_enable", 64'(write_control.enable), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pending",   64'(pending), 64'(0));
    check("mid_rst_wc_enable", 64'(write_control.enable), 64'(0));
    check("mid_rst_stall",     64'(stall), 64'(0));
    model_reset();
    long_valid = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    repeat (2) step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      if (!last_force) begin
        pipe_wb = '{enable: ($urandom_range(0, 3) != 0),
                    which_register: rv_reg_t'($urandom_range(0, 7)),
                    value: $urandom()};
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = rv_reg_t'($urandom_range(0, 7));
      rs1         = rv_reg_t'($urandom_range(0, 7));
      rs2         = rv_reg_t'($urandom_range(0, 7));
      if (!long_valid && $urandom_range(0, 2) == 0) begin
        cand.delete();
        for (int r = 1; r < NUM_REGS; r++) if (m_out[r]) cand.push_back(rv_reg_t'(r));
        if (cand.size() > 0) present_long(cand[$urandom_range(0, cand.size() - 1)], $urandom());
        else if ($urandom_range(0, 9) == 0) present_long(5'd0, $urandom());
      end
      step();
    end

    idle_inputs();
    repeat (MAX_WAIT + 6) step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
